// File: rtl/pipelined_csel_adder.sv
// ---------------------------------------------------------------------------
// pipelined_csel_adder
//
// Parametrised carry-select adder split into NSTG pipeline stages. Each stage
// resolves SEG_PER_STAGE segments of BLK_W bits. For every segment it computes
// the sum for carry-in 0 and carry-in 1 in parallel, then picks one with a 2:1
// mux driven by the incoming segment carry.
//
// The pipeline is skewed. Each stage register carries four things forward:
//   - the sum bits resolved so far,
//   - the operand bits not yet consumed,
//   - the carry out of the last resolved segment,
//   - a valid bit.
// Stages are linked by a valid/ready handshake with no skid buffer. A stage
// can load when it is empty or when its current contents are leaving in the
// same cycle.
//
// Optional feature: define CSEL_OVF_EN to add the registered signed-overflow
// output ovf.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set a/b/cin presented
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   a, b       unsigned operands, WIDTH bits
//   cin        carry in
//   out_valid  sum/cout valid
//   out_ready  downstream accepts result
//   sum        a+b+cin modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        (CSEL_OVF_EN only) two's-complement overflow of the result
// ---------------------------------------------------------------------------
module pipelined_csel_adder #(
  parameter int WIDTH         = 16,
  parameter int BLK_W         = 4,
  parameter int SEG_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = WIDTH / BLK_W;
  localparam int NSTG = NSEG / SEG_PER_STAGE;
  localparam int SW   = BLK_W * SEG_PER_STAGE;  // bits resolved per stage

  // Link index k is the input of stage k. Index 0 is the block input.
  // Index NSTG is the output register.
  logic [NSTG:0]    lnk_valid;
  logic [NSTG:0]    lnk_carry;
  logic [WIDTH-1:0] lnk_a   [NSTG+1];
  logic [WIDTH-1:0] lnk_b   [NSTG+1];
  logic [WIDTH-1:0] lnk_sum [NSTG+1];

  // ready[k] means stage k may load. ready[NSTG] is the downstream sink.
  logic [NSTG:0]    ready;

  assign lnk_valid[0] = in_valid;
  assign lnk_carry[0] = cin;
  assign lnk_a[0]     = a;
  assign lnk_b[0]     = b;
  assign lnk_sum[0]   = '0;
  assign ready[NSTG]  = out_ready;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NSTG; gi++) begin : g_stage
      localparam int LO = gi * SW;

      logic [SEG_PER_STAGE:0] seg_carry;
      logic [SW-1:0]          seg_sum;
      logic [WIDTH-1:0]       sum_next;
      logic                   valid_reg;
      logic                   carry_reg;
      logic [WIDTH-1:0]       sum_reg;
      logic [WIDTH-1:0]       a_reg;
      logic [WIDTH-1:0]       b_reg;

      assign seg_carry[0] = lnk_carry[gi];

      for (gj = 0; gj < SEG_PER_STAGE; gj++) begin : g_seg
        localparam int BIT = LO + gj * BLK_W;
        logic [BLK_W:0] res0;
        logic [BLK_W:0] res1;
        // Both carry-in hypotheses are computed side by side. The incoming
        // carry then only drives the select, so the carry chain per segment
        // is a single mux.
        assign res0 = {1'b0, lnk_a[gi][BIT +: BLK_W]} + {1'b0, lnk_b[gi][BIT +: BLK_W]};
        assign res1 = {1'b0, lnk_a[gi][BIT +: BLK_W]} + {1'b0, lnk_b[gi][BIT +: BLK_W]}
                      + {{BLK_W{1'b0}}, 1'b1};
        assign {seg_carry[gj+1], seg_sum[gj*BLK_W +: BLK_W]} = seg_carry[gj] ? res1 : res0;
      end

      // Keep the bits resolved by earlier stages. Overlay this stage's slice.
      always_comb begin
        sum_next           = lnk_sum[gi];
        sum_next[LO +: SW] = seg_sum;
      end

      assign ready[gi] = ~valid_reg | ready[gi+1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (ready[gi]) begin
          valid_reg <= lnk_valid[gi];
          if (lnk_valid[gi]) begin
            carry_reg <= seg_carry[SEG_PER_STAGE];
            sum_reg   <= sum_next;
          end
        end
      end

      // Operand bits are pure payload. Their value is irrelevant while the
      // stage is invalid, so these registers have no reset.
      always_ff @(posedge clk) begin
        if (ready[gi] && lnk_valid[gi]) begin
          a_reg <= lnk_a[gi];
          b_reg <= lnk_b[gi];
        end
      end

      assign lnk_valid[gi+1] = valid_reg;
      assign lnk_carry[gi+1] = carry_reg;
      assign lnk_sum[gi+1]   = sum_reg;
      assign lnk_a[gi+1]     = a_reg;
      assign lnk_b[gi+1]     = b_reg;

`ifdef CSEL_OVF_EN
      if (gi == NSTG - 1) begin : g_ovf
        logic ovf_reg;
        logic top_carry_in;
        // Carry into the MSB is recovered as a^b^sum at that bit.
        assign top_carry_in = lnk_a[gi][WIDTH-1] ^ lnk_b[gi][WIDTH-1] ^ seg_sum[SW-1];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (ready[gi] && lnk_valid[gi]) begin
            ovf_reg <= top_carry_in ^ seg_carry[SEG_PER_STAGE];
          end
        end
        assign ovf = ovf_reg;
      end
`endif
    end
  endgenerate

  assign in_ready  = ready[0];
  assign out_valid = lnk_valid[NSTG];
  assign sum       = lnk_sum[NSTG];
  assign cout      = lnk_carry[NSTG];

endmodule
